// File: rtl/execute_stage_pkg.sv
// Shared encodings for the EX stage: ALU ops, RV32M ops, mul/div FSM states
// and the sideband bundle that travels from pype1 into pype2.
package execute_stage_pkg;

  localparam int XLEN_W       = 32;
  localparam int MD_STEPS_DEF = 32;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_ctrl_e;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  typedef struct packed {
    logic [2:0]        wb;
    logic [1:0]        mem_rw;
    logic [1:0]        dsize;
    logic [2:0]        funct3;
    logic [XLEN_W-1:0] pcp4;
    logic [XLEN_W-1:0] rd2;
    logic [4:0]        wreg;
  } sideband_t;

  function automatic logic md_a_signed(input logic [2:0] f3);
    case (f3)
      MD_MULHU, MD_DIVU, MD_REMU: return 1'b0;
      default:                    return 1'b1;
    endcase
  endfunction

  function automatic logic md_b_signed(input logic [2:0] f3);
    case (f3)
      MD_MUL, MD_MULH, MD_DIV, MD_REM: return 1'b1;
      default:                         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/execute_stage_muldiv_iter.sv
// Iterative RV32M unit: operands are reduced to magnitudes, one bit per cycle
// is produced by shift-add or restoring shift-subtract, signs are fixed in DONE.
module muldiv_iter
  import execute_stage_pkg::*;
#(
  parameter int XLEN     = XLEN_W,
  parameter int MD_STEPS = MD_STEPS_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic            hold,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            active,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(MD_STEPS + 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e       state_reg, state_next;
  logic [XLEN-1:0] hi_reg, lo_reg, dvsr_reg;
  logic [CW-1:0]   cnt_reg;
  logic [2:0]      op_reg;
  logic            neg_reg, special_reg;

  logic            a_neg, b_neg, special_in;
  logic [XLEN-1:0] abs_a, abs_b, special_val;
  logic [XLEN:0]   mul_sum, div_tmp;
  logic            div_ge;
  logic [XLEN-1:0] div_diff, div_rem_next;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0] q_fix, r_fix;

  // Divide-by-zero and signed overflow are resolved at issue and skip BUSY.
  always_comb begin
    a_neg       = md_a_signed(funct3) & op_a[XLEN-1];
    b_neg       = md_b_signed(funct3) & op_b[XLEN-1];
    abs_a       = a_neg ? -op_a : op_a;
    abs_b       = b_neg ? -op_b : op_b;
    special_in  = 1'b0;
    special_val = '0;
    if (funct3[2]) begin
      if (op_b == '0) begin
        special_in  = 1'b1;
        special_val = funct3[1] ? op_a : '1;
      end else if (!funct3[0] && op_a == MIN_NEG && op_b == '1) begin
        special_in  = 1'b1;
        special_val = funct3[1] ? '0 : MIN_NEG;
      end
    end
  end

  always_comb begin
    mul_sum      = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, dvsr_reg} : '0);
    div_tmp      = {hi_reg, lo_reg[XLEN-1]};
    div_ge       = div_tmp >= {1'b0, dvsr_reg};
    div_diff     = div_tmp[XLEN-1:0] - dvsr_reg;
    div_rem_next = div_ge ? div_diff : div_tmp[XLEN-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= MD_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      MD_IDLE: if (start) state_next = special_in ? MD_DONE : MD_BUSY;
      MD_BUSY: begin
        if (abort)                    state_next = MD_IDLE;
        else if (cnt_reg == CW'(1))   state_next = MD_DONE;
      end
      MD_DONE: if (!hold) state_next = MD_IDLE;
      default: state_next = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_reg      <= '0;
      lo_reg      <= '0;
      dvsr_reg    <= '0;
      cnt_reg     <= '0;
      op_reg      <= '0;
      neg_reg     <= 1'b0;
      special_reg <= 1'b0;
    end else begin
      case (state_reg)
        MD_IDLE: if (start) begin
          op_reg      <= funct3;
          special_reg <= special_in;
          cnt_reg     <= CW'(MD_STEPS);
          hi_reg      <= '0;
          lo_reg      <= special_in ? special_val : abs_a;
          dvsr_reg    <= abs_b;
          // Remainder takes the dividend's sign; everything else the product sign.
          neg_reg     <= (funct3[2] & funct3[1]) ? a_neg : (a_neg ^ b_neg);
        end
        MD_BUSY: begin
          cnt_reg <= cnt_reg - CW'(1);
          if (op_reg[2]) begin
            hi_reg <= div_rem_next;
            lo_reg <= {lo_reg[XLEN-2:0], div_ge};
          end else begin
            hi_reg <= mul_sum[XLEN:1];
            lo_reg <= {mul_sum[0], lo_reg[XLEN-1:1]};
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    prod_fix = neg_reg ? -{hi_reg, lo_reg} : {hi_reg, lo_reg};
    q_fix    = neg_reg ? -lo_reg : lo_reg;
    r_fix    = neg_reg ? -hi_reg : hi_reg;
    if (special_reg) result = lo_reg;
    else begin
      case (op_reg)
        MD_MUL:                      result = prod_fix[XLEN-1:0];
        MD_MULH, MD_MULHSU, MD_MULHU: result = prod_fix[2*XLEN-1:XLEN];
        MD_DIV, MD_DIVU:             result = q_fix;
        default:                     result = r_fix;
      endcase
    end
  end

  assign active = (state_reg == MD_BUSY);
  assign done   = (state_reg == MD_DONE);

endmodule

// File: rtl/execute_stage.sv
// EX stage: single-cycle ALU, iterative RV32M unit, and the pype2 register
// bank (hold > flush > M-bubble > capture) consumed by mem_access.
module execute_stage
  import execute_stage_pkg::*;
#(
  parameter int XLEN     = XLEN_W,
  parameter int MD_STEPS = MD_STEPS_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            keep,
  input  logic            nop,
  input  logic [XLEN-1:0] alu_a,
  input  logic [XLEN-1:0] alu_b,
  input  logic [3:0]      alu_ctrl_pype1,
  input  logic            is_md_pype1,
  input  logic [2:0]      funct3_pype1,
  input  logic [2:0]      writeback_control_pype1,
  input  logic [1:0]      MemRW_pype1,
  input  logic [1:0]      dsize_pype1,
  input  logic [XLEN-1:0] PCp4_pype1,
  input  logic [XLEN-1:0] read_data2_pype1,
  input  logic [4:0]      WReg_pype1,
  output logic            md_busy,
  output logic [XLEN-1:0] ALU_co_pype,
  output logic [2:0]      writeback_control_pype2,
  output logic [1:0]      MemRW_pype2,
  output logic [1:0]      dsize_pype2,
  output logic [2:0]      funct3_pype2,
  output logic [XLEN-1:0] PCp4_pype2,
  output logic [XLEN-1:0] read_data2_pype2,
  output logic [4:0]      WReg_pype2
);

  localparam int SHW = $clog2(XLEN);

  sideband_t       side_in, side_lat_reg, side_pype2_reg;
  logic [XLEN-1:0] alu_res, alu_co_reg, md_result;
  logic            md_start, md_active, md_done;

  always_comb begin
    side_in.wb     = writeback_control_pype1;
    side_in.mem_rw = MemRW_pype1;
    side_in.dsize  = dsize_pype1;
    side_in.funct3 = funct3_pype1;
    side_in.pcp4   = PCp4_pype1;
    side_in.rd2    = read_data2_pype1;
    side_in.wreg   = WReg_pype1;
  end

  always_comb begin
    alu_res = '0;
    case (alu_ctrl_pype1)
      ALU_ADD:   alu_res = alu_a + alu_b;
      ALU_SUB:   alu_res = alu_a - alu_b;
      ALU_SLL:   alu_res = alu_a << alu_b[SHW-1:0];
      ALU_SLT:   alu_res = {{(XLEN-1){1'b0}}, $signed(alu_a) < $signed(alu_b)};
      ALU_SLTU:  alu_res = {{(XLEN-1){1'b0}}, alu_a < alu_b};
      ALU_XOR:   alu_res = alu_a ^ alu_b;
      ALU_SRL:   alu_res = alu_a >> alu_b[SHW-1:0];
      ALU_SRA:   alu_res = $unsigned($signed(alu_a) >>> alu_b[SHW-1:0]);
      ALU_OR:    alu_res = alu_a | alu_b;
      ALU_AND:   alu_res = alu_a & alu_b;
      ALU_PASSB: alu_res = alu_b;
      default:   alu_res = '0;
    endcase
  end

  // A flushed or stalled M op must not start; the unit is idle only outside BUSY/DONE.
  assign md_start = is_md_pype1 & ~keep & ~nop & ~md_active & ~md_done;
  assign md_busy  = md_start | md_active;

  muldiv_iter #(
    .XLEN     (XLEN),
    .MD_STEPS (MD_STEPS)
  ) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (md_start),
    .abort  (nop & ~keep),
    .hold   (keep),
    .funct3 (funct3_pype1),
    .op_a   (alu_a),
    .op_b   (alu_b),
    .active (md_active),
    .done   (md_done),
    .result (md_result)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           side_lat_reg <= '0;
    else if (md_start) side_lat_reg <= side_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_co_reg     <= '0;
      side_pype2_reg <= '0;
    end else if (!keep) begin
      if (nop) begin
        alu_co_reg     <= '0;
        side_pype2_reg <= '0;
      end else if (md_done) begin
        alu_co_reg     <= md_result;
        side_pype2_reg <= side_lat_reg;
      end else if (is_md_pype1 || md_active) begin
        alu_co_reg     <= '0;
        side_pype2_reg <= '0;
      end else begin
        alu_co_reg     <= alu_res;
        side_pype2_reg <= side_in;
      end
    end
  end

  assign ALU_co_pype             = alu_co_reg;
  assign writeback_control_pype2 = side_pype2_reg.wb;
  assign MemRW_pype2             = side_pype2_reg.mem_rw;
  assign dsize_pype2             = side_pype2_reg.dsize;
  assign funct3_pype2            = side_pype2_reg.funct3;
  assign PCp4_pype2              = side_pype2_reg.pcp4;
  assign read_data2_pype2        = side_pype2_reg.rd2;
  assign WReg_pype2              = side_pype2_reg.wreg;

endmodule

// File: tb/tb_execute_stage.sv
// Randomized bench for execute_stage against an arithmetic reference model
// of the ALU and RV32M ops, plus directed keep/nop/reset scenarios.
module tb_execute_stage;
  import execute_stage_pkg::*;

  localparam int STEPS = 32;

  logic        clk = 1'b0;
  logic        rst, keep, nop;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_ctrl_pype1;
  logic        is_md_pype1;
  logic [2:0]  funct3_pype1, writeback_control_pype1;
  logic [1:0]  MemRW_pype1, dsize_pype1;
  logic [31:0] PCp4_pype1, read_data2_pype1;
  logic [4:0]  WReg_pype1;
  logic        md_busy;
  logic [31:0] ALU_co_pype;
  logic [2:0]  writeback_control_pype2, funct3_pype2;
  logic [1:0]  MemRW_pype2, dsize_pype2;
  logic [31:0] PCp4_pype2, read_data2_pype2;
  logic [4:0]  WReg_pype2;

  int errors = 0;
  int checks = 0;
  logic [78:0] exp_side;

  execute_stage dut (
    .clk(clk), .rst(rst), .keep(keep), .nop(nop),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl_pype1(alu_ctrl_pype1),
    .is_md_pype1(is_md_pype1), .funct3_pype1(funct3_pype1),
    .writeback_control_pype1(writeback_control_pype1), .MemRW_pype1(MemRW_pype1),
    .dsize_pype1(dsize_pype1), .PCp4_pype1(PCp4_pype1),
    .read_data2_pype1(read_data2_pype1), .WReg_pype1(WReg_pype1),
    .md_busy(md_busy), .ALU_co_pype(ALU_co_pype),
    .writeback_control_pype2(writeback_control_pype2), .MemRW_pype2(MemRW_pype2),
    .dsize_pype2(dsize_pype2), .funct3_pype2(funct3_pype2), .PCp4_pype2(PCp4_pype2),
    .read_data2_pype2(read_data2_pype2), .WReg_pype2(WReg_pype2)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "simulation time limit reached");
  end

  task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [78:0] pype2_side();
    return {writeback_control_pype2, MemRW_pype2, dsize_pype2, funct3_pype2,
            PCp4_pype2, read_data2_pype2, WReg_pype2};
  endfunction

  function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] s;
    int sh;
    s  = $signed(a);
    sh = int'(b[4:0]);
    case (c)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a << sh;
      4'd3:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd4:    return (a < b) ? 32'd1 : 32'd0;
      4'd5:    return a ^ b;
      4'd6:    return a >> sh;
      4'd7:    return s >>> sh;
      4'd8:    return a | b;
      4'd9:    return a & b;
      4'd10:   return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic md_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    return f3[2] && (b == 32'd0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ub, p;
    logic [63:0] up;
    logic ovf;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ub  = {32'd0, b};
    ovf = (a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        return $signed(a) / $signed(b);
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (ovf) return 32'd0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_side(input logic [2:0] f3);
    writeback_control_pype1 = 3'($urandom);
    MemRW_pype1             = 2'($urandom);
    dsize_pype1             = 2'($urandom);
    funct3_pype1            = f3;
    PCp4_pype1              = $urandom;
    read_data2_pype1        = $urandom;
    WReg_pype1              = 5'($urandom_range(1, 31));
    exp_side = {writeback_control_pype1, MemRW_pype1, dsize_pype1, funct3_pype1,
                PCp4_pype1, read_data2_pype1, WReg_pype1};
  endtask

  task automatic do_alu(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp;
    exp            = ref_alu(ctrl, a, b);
    is_md_pype1    = 1'b0;
    alu_ctrl_pype1 = ctrl;
    alu_a          = a;
    alu_b          = b;
    drive_side(3'($urandom));
    #1;
    check_eq("alu_busy", 96'(md_busy), 96'(0));
    tick();
    check_eq($sformatf("alu_op%0d", ctrl), 96'(ALU_CO_WRAP()), 96'(exp));
    check_eq("alu_side", 96'(pype2_side()), 96'(exp_side));
    $display("txn alu ctrl=%0d a=%h b=%h res=%h", ctrl, a, b, ALU_co_pype);
  endtask

  function automatic logic [31:0] ALU_CO_WRAP();
    return ALU_co_pype;
  endfunction

  task automatic do_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp;
    int lat, busy_n;
    bit bubble_ok;
    exp            = ref_md(f3, a, b);
    lat            = md_special(f3, a, b) ? 2 : STEPS + 2;
    is_md_pype1    = 1'b1;
    alu_ctrl_pype1 = 4'($urandom_range(0, 10));
    alu_a          = a;
    alu_b          = b;
    drive_side(f3);
    #1;
    busy_n    = int'(md_busy);
    bubble_ok = 1'b1;
    for (int k = 1; k <= lat; k++) begin
      tick();
      if (k < lat) begin
        if ({ALU_co_pype, pype2_side()} != '0) bubble_ok = 1'b0;
        busy_n += int'(md_busy);
      end
    end
    check_eq($sformatf("md_res_f%0d", f3), 96'(ALU_co_pype), 96'(exp));
    check_eq("md_side", 96'(pype2_side()), 96'(exp_side));
    check_eq("md_busy_cycles", 96'(busy_n), 96'(lat - 1));
    check_eq("md_bubbles", 96'(bubble_ok), 96'(1));
    is_md_pype1 = 1'b0;
    $display("txn md f3=%0d a=%h b=%h res=%h lat=%0d", f3, a, b, ALU_co_pype, lat);
  endtask

  initial begin
    logic [78:0] prev_side;
    logic [4:0]  wreg_save;
    int          appear_n, appear_k;
    bit          busy_low_ok;

    rst = 1'b1; keep = 1'b0; nop = 1'b0;
    alu_a = '0; alu_b = '0; alu_ctrl_pype1 = '0; is_md_pype1 = 1'b0;
    funct3_pype1 = '0; writeback_control_pype1 = '0; MemRW_pype1 = '0;
    dsize_pype1 = '0; PCp4_pype1 = '0; read_data2_pype1 = '0; WReg_pype1 = '0;
    #2;
    check_eq("rst_alu", 96'(ALU_co_pype), 96'(0));
    check_eq("rst_side", 96'(pype2_side()), 96'(0));
    check_eq("rst_busy", 96'(md_busy), 96'(0));
    tick();
    tick();
    rst = 1'b0;

    do_alu(ALU_ADD, 32'h7FFF_FFFF, 32'd1);
    do_alu(ALU_SRA, 32'h8000_0000, 32'd4);
    do_alu(ALU_SLTU, 32'd1, 32'hFFFF_FFFF);

    // keep freezes pype2 even while a new op is presented
    prev_side = exp_side;
    keep = 1'b1;
    alu_ctrl_pype1 = ALU_ADD; alu_a = $urandom; alu_b = $urandom;
    drive_side(3'd0);
    tick();
    check_eq("keep_res", 96'(ALU_co_pype), 96'(1));
    check_eq("keep_side", 96'(pype2_side()), 96'(prev_side));
    keep = 1'b0;

    nop = 1'b1;
    tick();
    check_eq("nop_bank", 96'({ALU_co_pype, pype2_side()}), 96'(0));
    nop = 1'b0;

    do_alu(ALU_PASSB, 32'd0, 32'hCAFE_0001);
    prev_side = exp_side;
    keep = 1'b1; nop = 1'b1;
    drive_side(3'd1);
    tick();
    check_eq("keepnop_res", 96'(ALU_co_pype), 96'(32'hCAFE_0001));
    check_eq("keepnop_side", 96'(pype2_side()), 96'(prev_side));
    keep = 1'b0; nop = 1'b0;

    for (int i = 0; i < 40; i++)
      do_alu(4'($urandom_range(0, 10)), pick(), pick());

    do_md(MD_MULH,  32'h8000_0000, 32'h8000_0000);
    do_md(MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_md(MD_DIV,   32'hFFFF_FFF9, 32'd2);
    do_md(MD_REM,   32'hFFFF_FFF9, 32'd2);
    do_md(MD_DIVU,  32'd7, 32'd0);
    do_md(MD_REM,   32'h8000_0000, 32'hFFFF_FFFF);
    do_md(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
    do_md(MD_REMU,  32'h1234_5678, 32'd0);
    do_md(MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_md(MD_MUL,   32'hFFFF_FFFD, 32'd7);
    for (int i = 0; i < 16; i++)
      do_md(3'($urandom_range(0, 7)), pick(), pick());
    do_alu(ALU_SUB, 32'd5, 32'd9);

    // DIVU 100/7 whose DONE is spanned by a 5-cycle keep
    is_md_pype1 = 1'b1; alu_ctrl_pype1 = ALU_ADD; alu_a = 32'd100; alu_b = 32'd7;
    drive_side(MD_DIVU);
    wreg_save = WReg_pype1;
    prev_side = exp_side;
    appear_n = 0; appear_k = 0; busy_low_ok = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (ALU_co_pype == 32'd14 && WReg_pype2 == wreg_save) begin
        appear_n++;
        appear_k = k;
      end
      if (k == 37) check_eq("keep_md_side", 96'(pype2_side()), 96'(prev_side));
      if (k == 38) check_eq("keep_md_next", 96'(ALU_co_pype), 96'(32'h1234));
      if (k == 37) begin
        is_md_pype1 = 1'b0; alu_ctrl_pype1 = ALU_PASSB; alu_b = 32'h1234;
        drive_side(3'd0);
      end
      keep = (k >= 31 && k <= 35);
      #1;
      if (k >= 33 && k <= 36 && md_busy) busy_low_ok = 1'b0;
    end
    keep = 1'b0;
    check_eq("keep_md_count", 96'(appear_n), 96'(1));
    check_eq("keep_md_cycle", 96'(appear_k), 96'(37));
    check_eq("keep_md_busy_low", 96'(busy_low_ok), 96'(1));
    $display("txn md keep divu 100/7 appeared=%0d at=%0d", appear_n, appear_k);

    // nop 10 cycles into a DIV
    is_md_pype1 = 1'b1; alu_a = $urandom; alu_b = 32'd5;
    drive_side(MD_DIV);
    for (int k = 1; k <= 10; k++) tick();
    nop = 1'b1;
    #1;
    check_eq("nop_md_busy_same", 96'(md_busy), 96'(1));
    tick();
    check_eq("nop_md_bank", 96'({ALU_co_pype, pype2_side()}), 96'(0));
    nop = 1'b0;
    $display("txn md nop abort");
    do_alu(ALU_ADD, 32'd40, 32'd2);

    // asynchronous reset with live pype2 contents, then during BUSY
    do_alu(ALU_XOR, 32'hFFFF_0000, 32'h0F0F_0F0F);
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_bank", 96'({ALU_co_pype, pype2_side()}), 96'(0));
    tick();
    rst = 1'b0;
    is_md_pype1 = 1'b1; alu_a = 32'hFFFF_FF00; alu_b = 32'd3;
    drive_side(MD_DIV);
    for (int k = 1; k <= 5; k++) tick();
    #2;
    rst = 1'b1;
    is_md_pype1 = 1'b0;
    #1;
    check_eq("rst_busy_bank", 96'({ALU_co_pype, pype2_side()}), 96'(0));
    check_eq("rst_busy_flag", 96'(md_busy), 96'(0));
    tick();
    rst = 1'b0;
    $display("txn reset during busy");
    do_md(MD_DIVU, 32'd10, 32'd3);
    do_alu(ALU_OR, 32'h00F0_0000, 32'h0000_000F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
